// File: rtl/data_fifo.sv
// First-word-fall-through FIFO that buffers filter result words for bus readout,
// with sticky overflow and threshold-interrupt flags.
module data_fifo #(
  parameter int AW = 4
) (
  input  logic          SYSRSTn,
  input  logic          SYSCLK,
  input  logic [31:0]   filt_data_in,
  input  logic          filt_data_update,
  input  logic          reg_fifoen,
  input  logic [AW-1:0] reg_fifolvl,
  input  logic          reg_fifoien,
  input  logic          fifo_rd,
  input  logic          int_clr,
  input  logic          ovf_clr,
  output logic [31:0]   fifo_data_out,
  output logic [AW:0]   fifo_count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          fifo_ovf,
  output logic          fifo_int
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp_reg, rp_reg;
  logic [AW:0]   count_reg, count_next;
  logic [AW:0]   thr;
  logic          ovf_reg, int_reg;
  logic          pop_en, wr_en, ovf_set, int_set;

  assign fifo_count    = count_reg;
  assign fifo_empty    = (count_reg == '0);
  assign fifo_full     = (count_reg == (AW+1)'(DEPTH));
  assign fifo_ovf      = ovf_reg;
  assign fifo_int      = int_reg;
  assign fifo_data_out = fifo_empty ? 32'd0 : mem[rp_reg];
  assign thr           = {1'b0, reg_fifolvl} + (AW+1)'(1);

  // A full FIFO still accepts a word when the head is popped in the same cycle.
  // The interrupt is qualified by an accepted write, so a clear without a new
  // write sticks even while the level stays above the threshold.
  always_comb begin
    pop_en     = fifo_rd & reg_fifoen & ~fifo_empty;
    wr_en      = filt_data_update & reg_fifoen & (~fifo_full | pop_en);
    ovf_set    = filt_data_update & reg_fifoen & fifo_full & ~pop_en;
    count_next = count_reg;
    if (wr_en && !pop_en)
      count_next = count_reg + (AW+1)'(1);
    else if (pop_en && !wr_en)
      count_next = count_reg - (AW+1)'(1);
    int_set    = reg_fifoien & wr_en & (count_next >= thr);
  end

  always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      int_reg   <= 1'b0;
    end else if (!reg_fifoen) begin
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      int_reg   <= 1'b0;
    end else begin
      if (wr_en)
        wp_reg <= wp_reg + AW'(1);
      if (pop_en)
        rp_reg <= rp_reg + AW'(1);
      count_reg <= count_next;
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (ovf_clr)
        ovf_reg <= 1'b0;
      if (int_set)
        int_reg <= 1'b1;
      else if (int_clr)
        int_reg <= 1'b0;
    end
  end

  // Storage carries no reset; the empty check masks stale contents.
  always_ff @(posedge SYSCLK) begin
    if (wr_en)
      mem[wp_reg] <= filt_data_in;
  end

endmodule

// File: tb/tb_data_fifo.sv
// Directed bench for data_fifo: a queue-based model is checked every cycle,
// with literal expectations pinning the key scenario results.
module tb_data_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          SYSRSTn, SYSCLK;
  logic [31:0]   filt_data_in;
  logic          filt_data_update, reg_fifoen, reg_fifoien, fifo_rd, int_clr, ovf_clr;
  logic [AW-1:0] reg_fifolvl;
  logic [31:0]   fifo_data_out;
  logic [AW:0]   fifo_count;
  logic          fifo_empty, fifo_full, fifo_ovf, fifo_int;

  data_fifo #(.AW(AW)) dut (
    .SYSRSTn(SYSRSTn), .SYSCLK(SYSCLK), .filt_data_in(filt_data_in),
    .filt_data_update(filt_data_update), .reg_fifoen(reg_fifoen),
    .reg_fifolvl(reg_fifolvl), .reg_fifoien(reg_fifoien), .fifo_rd(fifo_rd),
    .int_clr(int_clr), .ovf_clr(ovf_clr), .fifo_data_out(fifo_data_out),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_ovf(fifo_ovf), .fifo_int(fifo_int)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_int = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 1'b0;
    m_int = 1'b0;
  endtask

  // Occupancy rules expressed on a queue, evaluated with the pre-edge inputs.
  task automatic model_update();
    bit do_pop, do_wr, was_full;
    if (!SYSRSTn || !reg_fifoen) begin
      model_clear();
      return;
    end
    was_full = (q.size() == DEPTH);
    do_pop   = fifo_rd && (q.size() > 0);
    do_wr    = filt_data_update && (!was_full || do_pop);
    if (do_pop) void'(q.pop_front());
    if (do_wr) q.push_back(filt_data_in);
    if (filt_data_update && was_full && !do_pop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (do_wr && reg_fifoien && (q.size() >= int'(reg_fifolvl) + 1)) m_int = 1'b1;
    else if (int_clr) m_int = 1'b0;
  endtask

  task automatic compare_all();
    chk("data_out", fifo_data_out, (q.size() > 0) ? q[0] : 32'd0);
    chk("count", 32'(fifo_count), 32'(q.size()));
    chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
    chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("ovf", 32'(fifo_ovf), 32'(m_ovf));
    chk("int", 32'(fifo_int), 32'(m_int));
  endtask

  // Inputs are set at a negedge; one clock later the outputs are compared.
  task automatic step();
    @(posedge SYSCLK);
    model_update();
    @(negedge SYSCLK);
    compare_all();
    filt_data_update = 1'b0;
    fifo_rd          = 1'b0;
    int_clr          = 1'b0;
    ovf_clr          = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d, input bit rd);
    filt_data_in     = d;
    filt_data_update = 1'b1;
    fifo_rd          = rd;
    step();
    $display("write %h rd=%0d -> count=%0d ovf=%0b int=%0b", d, rd, fifo_count, fifo_ovf, fifo_int);
  endtask

  task automatic rd_chk(input logic [31:0] exp);
    chk("pop_data", fifo_data_out, exp);
    fifo_rd = 1'b1;
    step();
    $display("read %h -> count=%0d", exp, fifo_count);
  endtask

  task automatic flush();
    reg_fifoen = 1'b0;
    step();
    reg_fifoen = 1'b1;
  endtask

  initial begin
    SYSRSTn = 1'b0; reg_fifoen = 1'b0; reg_fifoien = 1'b0; reg_fifolvl = '0;
    filt_data_in = '0; filt_data_update = 1'b0; fifo_rd = 1'b0;
    int_clr = 1'b0; ovf_clr = 1'b0;
    @(negedge SYSCLK);
    step();
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_data", fifo_data_out, 32'd0);
    SYSRSTn = 1'b1; reg_fifoen = 1'b1;
    step();

    // Scenario 1: three words in order
    wr(32'h11, 0); wr(32'h22, 0); wr(32'h33, 0);
    chk("s1_count", 32'(fifo_count), 32'd3);
    rd_chk(32'h11); rd_chk(32'h22); rd_chk(32'h33);
    chk("s1_empty", 32'(fifo_empty), 32'd1);
    chk("s1_data0", fifo_data_out, 32'd0);

    // Scenario 2: fill, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) wr(32'(i), 0);
    chk("s2_full", 32'(fifo_full), 32'd1);
    chk("s2_count", 32'(fifo_count), 32'd16);
    wr(32'hDEAD, 0);
    chk("s2_ovf", 32'(fifo_ovf), 32'd1);
    chk("s2_count_ovf", 32'(fifo_count), 32'd16);
    for (int i = 0; i < DEPTH; i++) rd_chk(32'(i));
    ovf_clr = 1'b1;
    step();
    chk("s2_ovf_clr", 32'(fifo_ovf), 32'd0);

    // Scenario 3: write and pop together while full
    for (int i = 0; i < DEPTH; i++) wr(32'h100 + 32'(i), 0);
    wr(32'hAAAA, 1);
    chk("s3_count", 32'(fifo_count), 32'd16);
    chk("s3_ovf", 32'(fifo_ovf), 32'd0);
    for (int i = 1; i < DEPTH; i++) rd_chk(32'h100 + 32'(i));
    rd_chk(32'hAAAA);

    // Scenario 4: threshold interrupt at level 3 (count 4)
    reg_fifolvl = 4'd3; reg_fifoien = 1'b1;
    wr(32'h1, 0); wr(32'h2, 0); wr(32'h3, 0);
    chk("s4_int_3rd", 32'(fifo_int), 32'd0);
    wr(32'h4, 0);
    chk("s4_int_4th", 32'(fifo_int), 32'd1);
    int_clr = 1'b1;
    wr(32'h5, 0);
    chk("s4_int_prio", 32'(fifo_int), 32'd1);
    int_clr = 1'b1;
    step();
    chk("s4_int_clr", 32'(fifo_int), 32'd0);
    reg_fifoien = 1'b0;
    for (int i = 1; i <= 5; i++) rd_chk(32'(i));

    // Scenario 5: pop-while-empty with write, then wrap-around traffic
    wr(32'h5, 1);
    chk("s5_count", 32'(fifo_count), 32'd1);
    chk("s5_data", fifo_data_out, 32'h5);
    rd_chk(32'h5);
    for (int i = 0; i < 20; i++) wr(32'h200 + 32'(i), (i % 2) == 1);
    chk("s5_count_wrap", 32'(fifo_count), 32'd10);
    chk("s5_head_wrap", fifo_data_out, 32'h20A);
    for (int i = 10; i < 20; i++) rd_chk(32'h200 + 32'(i));

    // Scenario 6a: flags and queue flushed by reg_fifoen=0
    reg_fifolvl = 4'd3; reg_fifoien = 1'b1;
    for (int i = 0; i <= DEPTH; i++) wr(32'h300 + 32'(i), 0);
    for (int i = 0; i < 11; i++) rd_chk(32'h300 + 32'(i));
    chk("s6_pre_count", 32'(fifo_count), 32'd5);
    chk("s6_pre_ovf", 32'(fifo_ovf), 32'd1);
    chk("s6_pre_int", 32'(fifo_int), 32'd1);
    flush();
    chk("s6_en_count", 32'(fifo_count), 32'd0);
    chk("s6_en_ovf", 32'(fifo_ovf), 32'd0);
    chk("s6_en_int", 32'(fifo_int), 32'd0);

    // Scenario 6b: asynchronous reset mid-cycle takes effect without an edge
    for (int i = 0; i <= DEPTH; i++) wr(32'h400 + 32'(i), 0);
    #2 SYSRSTn = 1'b0;
    #1;
    model_clear();
    compare_all();
    chk("s6_rst_count", 32'(fifo_count), 32'd0);
    chk("s6_rst_empty", 32'(fifo_empty), 32'd1);
    chk("s6_rst_data", fifo_data_out, 32'd0);
    chk("s6_rst_flags", 32'({fifo_ovf, fifo_int}), 32'd0);
    @(negedge SYSCLK);
    step();
    SYSRSTn = 1'b1;
    step();
    wr(32'h77, 0);
    rd_chk(32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
